// File: rtl/spi_buffer_pkg.sv
// Shared constants and sizing helpers for the SPI receive buffer.
package spi_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/spi_buffer.sv
// SPI-slave receive buffer: deserialises DI while CS is low and publishes
// each completed word on Buffer with a one-cycle Changed pulse.
module spi_buffer
  import spi_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CS,
  input  logic                  DI,
  output logic [DATA_WIDTH-1:0] Buffer,
  output logic                  Changed
);

  localparam int            CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  word_done;

  // shift_next already contains the current DI, so it is the full word on the last bit
  generate
    if (LSB_FIRST) begin : g_lsb
      assign shift_next = {DI, shift_reg[DATA_WIDTH-1:1]};
    end else begin : g_msb
      assign shift_next = {shift_reg[DATA_WIDTH-2:0], DI};
    end
  endgenerate

  assign word_done = !CS && (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST || CS) begin
      cnt <= '0;
    end else if (word_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || CS) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Buffer  <= '0;
      Changed <= 1'b0;
    end else begin
      Changed <= word_done;
      if (word_done) begin
        Buffer <= shift_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_buffer.sv
// Directed self-checking bench for spi_buffer (LSB-first and MSB-first instances).
module tb_spi_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CS  = 1'b1;
  logic       DI  = 1'b0;
  logic [7:0] buf_lsb, buf_msb;
  logic       chg_lsb, chg_msb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  spi_buffer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .CLK(CLK), .RST(RST), .CS(CS), .DI(DI), .Buffer(buf_lsb), .Changed(chg_lsb)
  );

  spi_buffer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .CLK(CLK), .RST(RST), .CS(CS), .DI(DI), .Buffer(buf_msb), .Changed(chg_msb)
  );

  // One rising edge with the given controls, outputs settled afterwards.
  task automatic cycle(input logic rst, input logic cs, input logic di);
    @(negedge CLK);
    RST = rst;
    CS  = cs;
    DI  = di;
    @(posedge CLK);
    #1;
  endtask

  // Sends one 8-bit word LSB first; Changed must pulse only after the 8th bit.
  task automatic send_word(input logic [7:0] w, input string name, inout int pulses);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, w[i]);
      n_cmp++;
      if (chg_lsb !== (i == 7)) begin
        n_err++;
        $display("FAIL %s changed bit%0d: got %b want %b", name, i, chg_lsb, (i == 7));
      end
      if (chg_lsb === 1'b1) pulses++;
    end
    n_cmp++;
    if (buf_lsb !== w) begin
      n_err++;
      $display("FAIL %s buffer: got %h want %h", name, buf_lsb, w);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (buf_lsb !== 8'h00 || chg_lsb !== 1'b0) begin
        n_err++;
        $display("FAIL reset: got buf=%h chg=%b want 00/0", buf_lsb, chg_lsb);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (buf_lsb !== 8'h00 || chg_lsb !== 1'b0) begin
        n_err++;
        $display("FAIL idle_cs: got buf=%h chg=%b want 00/0", buf_lsb, chg_lsb);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    send_word(8'h7A, "t2_7a", pulses);
    send_word(8'h80, "t2_80", pulses);
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (chg_lsb !== 1'b0 || buf_lsb !== 8'h80 || pulses != 2) begin
      n_err++;
      $display("FAIL t2_after: got chg=%b buf=%h pulses=%0d want 0/80/2", chg_lsb, buf_lsb, pulses);
    end
  endtask

  task automatic test_new_frame;
    int pulses = 0;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    send_word(8'h0C, "t3_0c", pulses);
    send_word(8'h40, "t3_40", pulses);
    cycle(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (chg_lsb !== 1'b0 || buf_lsb !== 8'h40 || pulses != 2) begin
      n_err++;
      $display("FAIL t3_extra: got chg=%b buf=%h pulses=%0d want 0/40/2", chg_lsb, buf_lsb, pulses);
    end
  endtask

  task automatic test_realign;
    int pulses = 0;
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (chg_lsb !== 1'b0) begin
        n_err++;
        $display("FAIL t4_partial bit%0d: got chg=%b want 0", i, chg_lsb);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    send_word(8'hA5, "t4_a5", pulses);
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL t4_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_abort;
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1);
    // CS rises on what would have been the completing edge
    cycle(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (chg_lsb !== 1'b0 || buf_lsb !== 8'hA5) begin
      n_err++;
      $display("FAIL abort: got chg=%b buf=%h want 0/a5", chg_lsb, buf_lsb);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (buf_lsb !== 8'h00 || chg_lsb !== 1'b0) begin
      n_err++;
      $display("FAIL t5_reset: got buf=%h chg=%b want 00/0", buf_lsb, chg_lsb);
    end
    send_word(8'h3C, "t5_3c", pulses);
  endtask

  task automatic test_msb_first;
    logic [7:0] bits;
    bits = 8'b0000_0001;
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, bits[i]);
    n_cmp++;
    if (buf_msb !== 8'h80 || chg_msb !== 1'b1) begin
      n_err++;
      $display("FAIL t6_msb: got buf=%h chg=%b want 80/1", buf_msb, chg_msb);
    end
    n_cmp++;
    if (buf_lsb !== 8'h01) begin
      n_err++;
      $display("FAIL t6_lsb: got buf=%h want 01", buf_lsb);
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (chg_msb !== 1'b0 || buf_msb !== 8'h80) begin
      n_err++;
      $display("FAIL t6_hold: got buf=%h chg=%b want 80/0", buf_msb, chg_msb);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_new_frame();
    test_realign();
    test_abort();
    test_reset_mid();
    test_msb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
